// File: rtl/switch_pkg.sv
// Shared types and constants for the switch ingress path.
package switch_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 8;

  // Buffered packet; the source stamp is applied on the way out, not stored.
  typedef struct packed {
    logic [ADDR_W-1:0] target;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } shp_state_t;

  // One-hot mask for a switch port index.
  function automatic logic [ADDR_W-1:0] port_onehot(input int unsigned idx);
    port_onehot = ADDR_W'(1) << idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; head entry is visible on rd_data while non-empty.
module sync_fifo
  import switch_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type         elem_t = pkt_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  elem_t                  wr_data,
  input  logic                   pop,
  output elem_t                  rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  elem_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty guard the pointers so stray requests never corrupt state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are only meaningful below the level mark.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/port_ingress_shaper.sv
// Per-port ingress shaper: buffers host packets, drops illegal targets and
// paces emission into a switch port that cannot apply backpressure.
module port_ingress_shaper
  import switch_pkg::*;
#(
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned GAP     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [ADDR_W-1:0]      host_target,
  input  logic [DATA_W-1:0]      host_data,
  output logic                   out_valid,
  output logic [ADDR_W-1:0]      out_source,
  output logic [ADDR_W-1:0]      out_target,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             drop_count
);

  localparam int unsigned       CNT_W     = $clog2(GAP + 1) + 1;
  localparam logic [ADDR_W-1:0] SRC_STAMP = port_onehot(PORT_ID);

  shp_state_t        state;
  shp_state_t        state_n;
  logic [CNT_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  gap_cnt_n;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              load;
  logic              accept;
  logic              legal;
  pkt_t              wr_pkt;
  pkt_t              head;
  logic              valid_n;
  logic [ADDR_W-1:0] source_n;
  logic [ADDR_W-1:0] target_n;
  logic [DATA_W-1:0] data_n;

  // Ready follows the registered level only; held low throughout reset.
  assign host_ready = rst_n && !fifo_full;
  assign accept     = host_valid && host_ready;
  assign legal      = (host_target != '0) && ((host_target & SRC_STAMP) == '0);
  assign fifo_push  = accept && legal;
  assign wr_pkt     = '{target: host_target, data: host_data};

  sync_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (pkt_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (wr_pkt),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Filtered packets still complete the handshake; count them, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (accept && !legal && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Output pacing: next state, FIFO pop and next registered output values.
  // The last gap cycle pops directly so pulses land GAP+1 cycles apart.
  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    load      = 1'b0;
    fifo_pop  = 1'b0;
    valid_n   = 1'b0;
    source_n  = '0;
    target_n  = '0;
    data_n    = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_SEND: begin
        if (GAP == 0) begin
          if (!fifo_empty) load = 1'b1;
          else             state_n = ST_IDLE;
        end else begin
          gap_cnt_n = CNT_W'(GAP);
          state_n   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= CNT_W'(1)) begin
          gap_cnt_n = '0;
          if (!fifo_empty) load = 1'b1;
          else             state_n = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (load) begin
      fifo_pop = 1'b1;
      valid_n  = 1'b1;
      source_n = SRC_STAMP;
      target_n = head.target;
      data_n   = head.data;
      state_n  = ST_SEND;
    end
  end

  // State, gap counter and registered switch-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      out_valid  <= 1'b0;
      out_source <= '0;
      out_target <= '0;
      out_data   <= '0;
    end else begin
      state      <= state_n;
      gap_cnt    <= gap_cnt_n;
      out_valid  <= valid_n;
      out_source <= source_n;
      out_target <= target_n;
      out_data   <= data_n;
    end
  end

endmodule

// File: tb/tb_port_ingress_shaper.sv
// Bench for port_ingress_shaper: a packet-queue reference model checks the
// GAP=1 instance every cycle; extra instances cover other gaps and backpressure.
module tb_port_ingress_shaper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_valid = 1'b0;
  logic [3:0] host_target = 4'd0;
  logic [7:0] host_data = 8'd0;

  logic       host_ready, out_valid;
  logic [3:0] out_source, out_target, fifo_level;
  logic [7:0] out_data, drop_count;

  logic       g3_ready, g3_valid;
  logic [3:0] g3_source, g3_target, g3_level;
  logic [7:0] g3_data, g3_drops;

  logic       g0_ready, g0_valid;
  logic [3:0] g0_source, g0_target, g0_level;
  logic [7:0] g0_data, g0_drops;

  logic       gl_ready, gl_valid;
  logic [3:0] gl_source, gl_target, gl_level;
  logic [7:0] gl_data, gl_drops;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state for the main (GAP=1) instance.
  logic [11:0] exp_q[$];
  int m_pushed = 0;
  int m_popped = 0;
  int m_drops = 0;
  int last_pulse = -100;
  int g3_pulses[$];
  int g0_pulses[$];
  logic [7:0] gl_q[$];

  always #5 clk = ~clk;

  port_ingress_shaper #(.PORT_ID(1), .DEPTH(8), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(host_ready),
    .host_target(host_target), .host_data(host_data), .out_valid(out_valid),
    .out_source(out_source), .out_target(out_target), .out_data(out_data),
    .fifo_level(fifo_level), .drop_count(drop_count));

  port_ingress_shaper #(.PORT_ID(1), .DEPTH(8), .GAP(3)) dut_g3 (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(g3_ready),
    .host_target(host_target), .host_data(host_data), .out_valid(g3_valid),
    .out_source(g3_source), .out_target(g3_target), .out_data(g3_data),
    .fifo_level(g3_level), .drop_count(g3_drops));

  port_ingress_shaper #(.PORT_ID(1), .DEPTH(8), .GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(g0_ready),
    .host_target(host_target), .host_data(host_data), .out_valid(g0_valid),
    .out_source(g0_source), .out_target(g0_target), .out_data(g0_data),
    .fifo_level(g0_level), .drop_count(g0_drops));

  port_ingress_shaper #(.PORT_ID(1), .DEPTH(8), .GAP(40)) dut_gl (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(gl_ready),
    .host_target(host_target), .host_data(host_data), .out_valid(gl_valid),
    .out_source(gl_source), .out_target(gl_target), .out_data(gl_data),
    .fifo_level(gl_level), .drop_count(gl_drops));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: apply the model's view of the handshake, then check the main DUT.
  task automatic tick();
    logic       hv, rs, exp_rdy;
    logic [3:0] ht;
    logic [7:0] hd;
    logic [11:0] e;
    hv = host_valid;
    ht = host_target;
    hd = host_data;
    rs = rst_n;
    exp_rdy = rs && ((m_pushed - m_popped) < 8);
    @(posedge clk);
    #1;
    cyc++;
    if (!rs) begin
      exp_q.delete();
      g3_pulses.delete();
      g0_pulses.delete();
      gl_q.delete();
      m_pushed = 0;
      m_popped = 0;
      m_drops = 0;
      last_pulse = -100;
    end else if (hv && exp_rdy) begin
      if (ht == 4'd0 || ht[1]) begin
        if (m_drops < 255) m_drops++;
      end else begin
        exp_q.push_back({ht, hd});
        m_pushed++;
      end
    end
    if (out_valid) begin
      chk("out_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_target", 32'(out_target), 32'(e[11:8]));
        chk("out_data", 32'(out_data), 32'(e[7:0]));
        m_popped++;
      end
      chk("out_source", 32'(out_source), 32'd2);
      chk("pulse_spacing", 32'((cyc - last_pulse) >= 2), 1);
      last_pulse = cyc;
    end else begin
      chk("idle_zero", 32'({out_source, out_target, out_data}), 0);
    end
    chk("fifo_level", 32'(fifo_level), 32'(m_pushed - m_popped));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("host_ready", 32'(host_ready), 32'(rst_n && ((m_pushed - m_popped) < 8)));
    if (rs) begin
      if (g3_valid) g3_pulses.push_back(cyc);
      if (g0_valid) g0_pulses.push_back(cyc);
      if (gl_valid) gl_q.push_back(gl_data);
    end
  endtask

  task automatic do_reset();
    host_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int k, gl_seen, found;
    logic pre_rdy;

    // Reset values
    host_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ready_low", 32'(host_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(host_ready), 1);

    // Single packet, two-edge latency, stamped source
    host_valid = 1'b1; host_target = 4'b0100; host_data = 8'hA5;
    tick();
    host_valid = 1'b0;
    chk("a5_not_yet", 32'(out_valid), 0);
    tick();
    chk("a5_valid", 32'(out_valid), 1);
    chk("a5_source", 32'(out_source), 32'h2);
    chk("a5_target", 32'(out_target), 32'h4);
    chk("a5_data", 32'(out_data), 32'hA5);
    tick();
    chk("a5_one_cycle", 32'(out_valid), 0);
    repeat (4) tick();

    // Illegal targets: zero and self
    host_valid = 1'b1;
    host_target = 4'b0000; host_data = 8'h11; tick();
    host_target = 4'b0010; host_data = 8'h22; tick();
    host_target = 4'b0001; host_data = 8'h5A; tick();
    host_valid = 1'b0;
    repeat (6) tick();
    chk("drops_two", 32'(drop_count), 2);
    host_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      host_target = ($urandom_range(0, 3) == 0) ? 4'd0 : (4'($urandom_range(0, 15)) | 4'b0010);
      host_data = 8'($urandom);
      tick();
    end
    host_valid = 1'b0;
    tick();
    chk("drops_saturate", 32'(drop_count), 255);

    // Gap spacing on GAP=3 and GAP=0 instances
    do_reset();
    host_valid = 1'b1; host_target = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      host_data = 8'(8'h30 + i);
      tick();
    end
    host_valid = 1'b0;
    repeat (25) tick();
    chk("g3_pulse_count", 32'(g3_pulses.size()), 4);
    chk("g0_pulse_count", 32'(g0_pulses.size()), 4);
    for (int i = 1; i < 4; i++) begin
      if (i < g3_pulses.size()) chk("g3_spacing", 32'(g3_pulses[i] - g3_pulses[i-1]), 4);
      if (i < g0_pulses.size()) chk("g0_spacing", 32'(g0_pulses[i] - g0_pulses[i-1]), 1);
    end

    // Backpressure on the slow-draining instance
    do_reset();
    k = 1;
    host_valid = 1'b1; host_target = 4'b1000;
    for (int c = 0; c < 200 && k <= 10; c++) begin
      host_data = 8'(k);
      pre_rdy = gl_ready;
      gl_seen = gl_q.size();
      tick();
      if (pre_rdy) begin
        if (k == 9) begin
          chk("gl_full_level", 32'(gl_level), 8);
          chk("gl_full_ready", 32'(gl_ready), 0);
        end
        if (k == 10) chk("gl_stall_until_pop", 32'(gl_seen), 2);
        k++;
      end
    end
    host_valid = 1'b0;
    chk("gl_all_accepted", 32'(k), 11);
    for (int c = 0; c < 500 && gl_q.size() < 10; c++) tick();
    chk("gl_out_count", 32'(gl_q.size()), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < gl_q.size()) chk("gl_order", 32'(gl_q[i]), 32'(i + 1));
    end

    // Simultaneous push/pop at level 3, then random traffic across wrap
    do_reset();
    found = 0;
    host_valid = 1'b1; host_target = 4'b1000;
    for (int c = 0; c < 30; c++) begin
      host_data = 8'($urandom);
      tick();
      if (fifo_level == 4'd3 && !out_valid) begin
        found = 1;
        break;
      end
    end
    chk("level3_reached", 32'(found), 1);
    host_data = 8'($urandom);
    tick();
    chk("level_hold_pushpop", 32'(fifo_level), 3);
    chk("level_hold_pop_seen", 32'(out_valid), 1);
    for (int i = 0; i < 120; i++) begin
      host_valid = ($urandom_range(0, 3) != 0);
      host_target = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b1101 & 4'($urandom_range(1, 15));
      host_data = 8'($urandom);
      tick();
    end
    host_valid = 1'b0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) tick();
    chk("drained", 32'(exp_q.size()), 0);

    // Reset while a packet is on the wire and the FIFO holds 5
    found = 0;
    host_valid = 1'b1; host_target = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      host_data = 8'($urandom);
      tick();
      if (fifo_level == 4'd5 && out_valid) begin
        found = 1;
        break;
      end
    end
    chk("mid_state_reached", 32'(found), 1);
    rst_n = 1'b0;
    host_valid = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_drops", 32'(drop_count), 0);
    chk("mid_rst_ready", 32'(host_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", 32'(host_ready), 1);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
